// File: rtl/dac_update_sched_pkg.sv
// Shared definitions for the SPI DAC update scheduler:
// command codes, frame width, scheduler states and frame builder.
package dac_pkg;

    localparam int FRAME_W = 24;

    localparam logic [3:0] CMD_WRITE_IN   = 4'b0000;
    localparam logic [3:0] CMD_UPDATE_ALL = 4'b0010;
    localparam logic [3:0] CMD_WRITE_UPD  = 4'b0011;
    localparam logic [3:0] ADDR_ALL       = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_UPDATE
    } sched_state_t;

    // DAC frame layout: command, address, 12-bit data, 4 don't-care bits.
    function automatic logic [FRAME_W-1:0] mk_frame(
        input logic [3:0]  cmd,
        input logic [3:0]  addr,
        input logic [11:0] data
    );
        return {cmd, addr, data, 4'h0};
    endfunction

endpackage

// File: rtl/dac_update_sched_if.sv
// Voice-side sample write port and sample-rate tick of the
// DAC update scheduler.
interface dac_update_sched_if #(
    parameter int DW = 12
);
    logic          tick;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [DW-1:0] wr_data;

    modport master (output tick, wr_en, wr_ch, wr_data);
    modport slave  (input  tick, wr_en, wr_ch, wr_data);
endinterface

// File: rtl/dac_update_sched_spi_frame_tx.sv
// 24-bit SPI frame transmitter: sck = clk/2, MSB first, data
// changes with sck low, CS rises the clock after the last sck high.
module spi_frame_tx
    import dac_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_sck,
    output logic               o_sdo,
    output logic               o_cs,
    output logic               o_done,
    output logic               o_last
);

    logic [FRAME_W-1:0] r_sh;
    logic [4:0]         r_bit;
    logic               r_act;
    logic               r_sck;
    logic               r_sdo;
    logic               r_cs;
    logic               r_done;

    // High in the final sck-high clock, so the scheduler can step
    // into its gap on the same edge that raises CS.
    assign o_last = r_act & r_sck & (r_bit == 5'd0);

    assign o_sck  = r_sck;
    assign o_sdo  = r_sdo;
    assign o_cs   = r_cs;
    assign o_done = r_done;

    // Shift engine: load on start, then alternate sck low/high per bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh   <= '0;
            r_bit  <= '0;
            r_act  <= 1'b0;
            r_sck  <= 1'b0;
            r_sdo  <= 1'b0;
            r_cs   <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_act) begin
                if (i_start) begin
                    r_act <= 1'b1;
                    r_sdo <= i_frame[FRAME_W-1];
                    r_sh  <= {i_frame[FRAME_W-2:0], 1'b0};
                    r_bit <= 5'(FRAME_W - 1);
                    r_cs  <= 1'b0;
                    r_sck <= 1'b0;
                end
            end else if (!r_sck) begin
                r_sck <= 1'b1;
            end else if (r_bit == 5'd0) begin
                r_act  <= 1'b0;
                r_cs   <= 1'b1;
                r_sck  <= 1'b0;
                r_sdo  <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_sck <= 1'b0;
                r_sdo <= r_sh[FRAME_W-1];
                r_sh  <= {r_sh[FRAME_W-2:0], 1'b0};
                r_bit <= r_bit - 5'd1;
            end
        end
    end

endmodule

// File: rtl/dac_update_sched.sv
// Shares one 4-channel SPI DAC between voice outputs; sends every
// channel written since the last tick. Option: DAC_SCHED_SYNC_UPDATE_EN.
module dac_update_sched
    import dac_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 12,
    parameter int GAP_CYC = 2
) (
    input  logic               clk,
    input  logic               reset,
    dac_update_sched_if.slave  bus,
    output logic               spi_sck,
    output logic               spi_sdo,
    output logic               spi_dac_cs,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);

`ifdef DAC_SCHED_SYNC_UPDATE_EN
    localparam logic [3:0] CH_CMD = CMD_WRITE_IN;
`else
    localparam logic [3:0] CH_CMD = CMD_WRITE_UPD;
`endif

    logic [DW-1:0]      r_smp [NCH];
    logic [NCH-1:0]     r_dirty;
    logic [NCH-1:0]     r_pend;
    sched_state_t       r_state;
    logic [7:0]         r_gap;
    logic               r_busy;
    logic               r_ovr;
`ifdef DAC_SCHED_SYNC_UPDATE_EN
    logic               r_is_upd;
`endif

    logic               w_capture;
    logic               w_wr_ok;
    logic [NCH-1:0]     w_set;
    logic [NCH-1:0]     w_clr;
    logic [1:0]         w_sel;
    logic               w_start;
    logic [FRAME_W-1:0] w_frame;
    logic               w_tx_last;

    assign w_wr_ok   = bus.wr_en && (int'(bus.wr_ch) < NCH);
    assign w_capture = (r_state == ST_IDLE) && bus.tick && (|r_dirty);

    // Dirty set/clear masks; a same-cycle write re-sets the bit.
    always_comb begin
        w_set = '0;
        if (w_wr_ok) begin
            w_set[bus.wr_ch] = 1'b1;
        end
        w_clr = w_capture ? r_dirty : '0;
    end

    // Lowest pending channel wins.
    always_comb begin
        w_sel = '0;
        for (int n = NCH - 1; n >= 0; n--) begin
            if (r_pend[n]) begin
                w_sel = 2'(n);
            end
        end
    end

    // Frame presented to the transmitter during LOAD/UPDATE.
    always_comb begin
        w_start = (r_state == ST_LOAD);
        w_frame = mk_frame(CH_CMD, 4'(w_sel), 12'(r_smp[w_sel]));
`ifdef DAC_SCHED_SYNC_UPDATE_EN
        if (r_state == ST_UPDATE) begin
            w_start = 1'b1;
            w_frame = mk_frame(CMD_UPDATE_ALL, ADDR_ALL, 12'h000);
        end
`endif
    end

    // Sample registers and dirty flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dirty <= '0;
            for (int n = 0; n < NCH; n++) begin
                r_smp[n] <= '0;
            end
        end else begin
            r_dirty <= (r_dirty & ~w_clr) | w_set;
            if (w_wr_ok) begin
                r_smp[bus.wr_ch] <= bus.wr_data;
            end
        end
    end

    // Scheduler FSM with registered busy and overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pend   <= '0;
            r_gap    <= '0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
`ifdef DAC_SCHED_SYNC_UPDATE_EN
            r_is_upd <= 1'b0;
`endif
        end else begin
            r_ovr <= bus.tick && (r_state != ST_IDLE);
            unique case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_pend  <= r_dirty;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_pend[w_sel] <= 1'b0;
                    r_state       <= ST_SEND;
`ifdef DAC_SCHED_SYNC_UPDATE_EN
                    r_is_upd      <= 1'b0;
`endif
                end
                ST_SEND: begin
                    if (w_tx_last) begin
                        r_gap   <= 8'(GAP_CYC - 1);
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap != 8'd0) begin
                        r_gap <= r_gap - 8'd1;
                    end else if (|r_pend) begin
                        r_state <= ST_LOAD;
`ifdef DAC_SCHED_SYNC_UPDATE_EN
                    end else if (!r_is_upd) begin
                        r_state <= ST_UPDATE;
`endif
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`ifdef DAC_SCHED_SYNC_UPDATE_EN
                ST_UPDATE: begin
                    r_is_upd <= 1'b1;
                    r_state  <= ST_SEND;
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    spi_frame_tx u_tx (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_frame (w_frame),
        .o_sck   (spi_sck),
        .o_sdo   (spi_sdo),
        .o_cs    (spi_dac_cs),
        .o_done  (frame_done),
        .o_last  (w_tx_last)
    );

    assign busy    = r_busy;
    assign overrun = r_ovr;

endmodule
